axi4b_resp_gen: RTL

- Synthesizable AXI4 write-response (B channel) generator for the subordinate side of the AXI4 bus.
- The write-data path pushes one completion per accepted WLAST. The block queues each completion and drives bid/bresp/bvalid under bready backpressure.
- It has a programmable response delay and forced-error injection.
- It is the DUT-side counterpart that the axi4b BFM drives bready against and monitors in block and cosim benches.

---
 rtl/axi4b_pkg.sv | 24 ++
 rtl/axi4b_resp_fifo.sv | 57 +++++
 rtl/axi4b_resp_gen.sv | 111 +++++++++++
 3 files changed

// File: rtl/axi4b_pkg.sv
// Shared AXI4 B-channel definitions: response codes, queued entry layout, output FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi4b_pkg;

    localparam int ID_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } axi4b_resp_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        VALID
    } axi4b_resp_state_e;

endpackage

// File: rtl/axi4b_resp_fifo.sv
// Synchronous FIFO holding pending write completions; read data is the head entry (show-ahead).
// Latency: a push is visible at the head on the next cycle; pop consumes the head at the edge.
// Backpressure: full_o blocks pushes, empty_o blocks pops; illegal requests are ignored.
// Ports: push_i/push_dat_i write, pop_i/pop_dat_o read, count_o/full_o/empty_o status.
module axi4b_resp_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 pop_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally (DEPTH is a power of two); the count disambiguates full vs empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/axi4b_resp_gen.sv
// AXI4 write-response generator: queues completions and drives bid/bresp/bvalid.
// Latency: push in cycle N -> bvalid in cycle N+2+cfg_delay (empty, idle); back-to-back at delay 0.
// Backpressure: bready stalls the output register; cmp_ready drops when DEPTH entries are queued.
// Ports: cmp_* completion input, cfg_* delay/error-injection controls, b* AXI4 B channel,
//        fifo_count = entries queued behind the output register.
module axi4b_resp_gen
    import axi4b_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int DEPTH = 8,
    parameter int DLY_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmp_valid,
    output logic                       cmp_ready,
    input  logic [ID_W-1:0]            cmp_id,
    input  logic [1:0]                 cmp_resp,
    input  logic                       cfg_force_slverr,
    input  logic [DLY_W-1:0]           cfg_delay,
    output logic [ID_W-1:0]            bid,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);
    localparam int EW = ID_W + 2;

    axi4b_resp_state_e state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]     push_dat, head_dat;

    // Error injection is applied at enqueue so the flag only needs to be valid at the push edge.
    assign push_dat  = {cmp_id, (cfg_force_slverr ? RESP_SLVERR : cmp_resp)};
    assign cmp_ready = !fifo_full;

    axi4b_resp_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (cmp_valid),
        .push_dat_i (push_dat),
        .pop_i      (fifo_pop),
        .pop_dat_o  (head_dat),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            bid_q   <= '0;
            bresp_q <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            bid_q   <= bid_d;
            bresp_q <= bresp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dly_d    = dly_q;
        bid_d    = bid_q;
        bresp_d  = bresp_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    {bid_d, bresp_d} = head_dat;
                    dly_d   = cfg_delay;
                    state_d = (cfg_delay == '0) ? VALID : WAIT;
                end
            end
            WAIT: begin
                // dly_q counts down from cfg_delay; reaching 1 means the last idle cycle.
                if (dly_q == DLY_W'(1)) state_d = VALID;
                else                    dly_d   = dly_q - DLY_W'(1);
            end
            VALID: begin
                if (bready) begin
                    if (!fifo_empty) begin
                        // Reload in the handshake edge so delay 0 gives one response per cycle.
                        fifo_pop = 1'b1;
                        {bid_d, bresp_d} = head_dat;
                        dly_d   = cfg_delay;
                        state_d = (cfg_delay == '0) ? VALID : WAIT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bvalid = (state_q == VALID);
    assign bid    = bid_q;
    assign bresp  = bresp_q;

endmodule
